// File: rtl/elevator_call_scheduler.sv
// Request side of the elevator controller: latches floor calls, orders them with a
// collective (SCAN) sweep and drives the registered target floor.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 3,
    parameter int DOOR_HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic [1:0]            car_dir,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy,
    output logic                  served_pulse
);

    typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic                    sweep_up;
    logic [3:0]              hold_cnt;

    logic                    car_valid;
    logic [FLOOR_W-1:0]      car_eff;
    logic                    up_found, dn_found;
    logic [FLOOR_W-1:0]      up_sel, dn_sel;
    logic [FLOOR_W-1:0]      sel_floor;
    logic                    sel_rev;
    logic                    any_pending;
    logic [NUM_FLOORS-1:0]   tgt_mask, clear_mask, absorb_mask, pending_d;
    logic                    match;
    logic                    load_sel;

    // Direction is informational only; the sweep state is tracked internally.
    logic car_dir_unused;
    assign car_dir_unused = ^car_dir;

    // Nearest pending floor above and below the car, found by priority scan.
    always_comb begin
        // NOTE: every combinationally written signal gets a default first, so no latch is inferred.
        car_valid = (car_floor >= FLOOR_W'(1)) && (car_floor <= FLOOR_W'(NUM_FLOORS));
        car_eff   = car_valid ? car_floor : FLOOR_W'(1);
        up_found  = 1'b0;
        up_sel    = '0;
        dn_found  = 1'b0;
        dn_sel    = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i + 1) >= car_eff)) begin
                up_found = 1'b1;
                up_sel   = FLOOR_W'(i + 1);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i + 1) <= car_eff)) begin
                dn_found = 1'b1;
                dn_sel   = FLOOR_W'(i + 1);
            end
        end
        sel_floor = target_floor;
        sel_rev   = 1'b0;
        if (sweep_up) begin
            if (up_found) sel_floor = up_sel;
            else if (dn_found) begin
                sel_floor = dn_sel;
                sel_rev   = 1'b1;
            end
        end else begin
            if (dn_found) sel_floor = dn_sel;
            else if (up_found) begin
                sel_floor = up_sel;
                sel_rev   = 1'b1;
            end
        end
    end

    // Clear/absorb masks: a call on the floor being served or held never re-latches.
    always_comb begin
        any_pending = |pending;
        for (int i = 0; i < NUM_FLOORS; i++) tgt_mask[i] = (target_floor == FLOOR_W'(i + 1));
        match       = (state_q == SERVE) && door_open && car_valid &&
                      (car_floor == target_floor) && |(pending & tgt_mask);
        clear_mask  = match ? tgt_mask : '0;
        absorb_mask = clear_mask | ((state_q == HOLD) ? tgt_mask : '0);
        pending_d   = (pending | (call_btn & ~absorb_mask)) & ~clear_mask;
        load_sel    = any_pending && (((state_q == IDLE)) ||
                                      ((state_q == SERVE) && !match) ||
                                      ((state_q == HOLD) && (hold_cnt == 4'd0)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_pending) state_d = SERVE;
            SERVE: begin
                if (match)             state_d = HOLD;
                else if (!any_pending) state_d = IDLE;
            end
            HOLD:    if (hold_cnt == 4'd0) state_d = any_pending ? SERVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        served_pulse = match;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending      <= '0;
            target_floor <= FLOOR_W'(1);
            sweep_up     <= 1'b1;
            hold_cnt     <= 4'd0;
        end else begin
            pending <= pending_d;
            if (load_sel) begin
                target_floor <= sel_floor;
                if (sel_rev) sweep_up <= ~sweep_up;
            end else if ((state_q == IDLE) && car_valid) begin
                target_floor <= car_floor;
            end
            if (match)
                hold_cnt <= 4'(DOOR_HOLD - 1);
            else if ((state_q == HOLD) && (hold_cnt != 4'd0))
                hold_cnt <= hold_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: hand-computed targets, pending
// vectors and served pulses across reset, sweeps, reversal, absorption and invalid floors.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] call_btn;
    logic [2:0] car_floor;
    logic [1:0] car_dir;
    logic       door_open;
    logic [2:0] target_floor;
    logic [4:0] pending;
    logic       busy;
    logic       served_pulse;

    int n_total = 0;
    int n_bad   = 0;

    elevator_call_scheduler #(.NUM_FLOORS(5), .FLOOR_W(3), .DOOR_HOLD(4)) dut (
        .clk(clk), .rst(rst), .call_btn(call_btn), .car_floor(car_floor),
        .car_dir(car_dir), .door_open(door_open), .target_floor(target_floor),
        .pending(pending), .busy(busy), .served_pulse(served_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] floor);
        rst       = 1'b0;
        call_btn  = '0;
        door_open = 1'b0;
        car_dir   = 2'b00;
        car_floor = floor;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a call held: nothing latches until release.
        rst = 1'b0; call_btn = 5'b10000; car_floor = 3'd1; car_dir = 2'b00; door_open = 1'b0;
        repeat (2) tick();
        check("rst_pending", pending, 5'b00000);
        check("rst_target", target_floor, 3'd1);
        check("rst_busy", busy, 1'b0);
        check("rst_pulse", served_pulse, 1'b0);
        rst = 1'b1;
        tick();
        check("rel_pending", pending, 5'b10000);
        check("rel_target1", target_floor, 3'd1);
        check("rel_busy1", busy, 1'b0);
        tick();
        check("rel_target2", target_floor, 3'd5);
        check("rel_busy2", busy, 1'b1);

        // Calls 3 and 5 from floor 1; serve 3, hold, absorb floor-3 call, latch floor 4.
        do_reset(3'd1);
        call_btn = 5'b10100;
        tick();
        call_btn = '0;
        tick();
        check("up_first", target_floor, 3'd3);
        car_dir = 2'b01; car_floor = 3'd2;
        tick();
        car_floor = 3'd3; car_dir = 2'b11; door_open = 1'b1;
        #1;
        check("up_pulse", served_pulse, 1'b1);
        tick();
        check("up_pend_after", pending, 5'b10000);
        check("up_hold_t0", target_floor, 3'd3);
        check("up_pulse_off", served_pulse, 1'b0);
        tick();
        call_btn = 5'b01100;
        tick();
        call_btn = '0;
        check("absorb_pend", pending, 5'b11000);
        check("absorb_pulse", served_pulse, 1'b0);
        check("up_hold_t2", target_floor, 3'd3);
        tick();
        check("up_hold_t3", target_floor, 3'd3);
        tick();
        check("after_hold", target_floor, 3'd4);
        check("no_second_pulse", served_pulse, 1'b0);

        // Up sweep from 4 ignores call 2 until 5 is served, then reverses.
        do_reset(3'd4);
        call_btn = 5'b10000;
        tick();
        call_btn = '0;
        tick();
        check("rev_t5", target_floor, 3'd5);
        call_btn = 5'b00010;
        tick();
        call_btn = '0;
        tick();
        check("rev_keep5", target_floor, 3'd5);
        check("rev_pend", pending, 5'b10010);
        car_floor = 3'd5; door_open = 1'b1;
        #1;
        check("rev_pulse", served_pulse, 1'b1);
        repeat (4) tick();
        check("rev_hold5", target_floor, 3'd5);
        tick();
        check("rev_t2", target_floor, 3'd2);
        check("rev_pend2", pending, 5'b00010);
        door_open = 1'b0; car_floor = 3'd3; call_btn = 5'b01000;
        tick();
        call_btn = '0;
        tick();
        check("down_sweep", target_floor, 3'd2);

        // Call ahead of the moving car retargets it.
        do_reset(3'd1);
        call_btn = 5'b10000;
        tick();
        call_btn = '0;
        tick();
        check("ret_t5", target_floor, 3'd5);
        car_floor = 3'd2; call_btn = 5'b00100;
        tick();
        call_btn = '0;
        check("ret_before", target_floor, 3'd5);
        tick();
        check("ret_t3", target_floor, 3'd3);

        // IDLE tracks valid floors only; invalid floor never clears.
        do_reset(3'd3);
        tick();
        check("idle_track", target_floor, 3'd3);
        car_floor = 3'd6;
        tick();
        check("idle_invalid", target_floor, 3'd3);
        check("idle_busy", busy, 1'b0);
        car_floor = 3'd1; call_btn = 5'b00001;
        tick();
        call_btn = '0;
        tick();
        check("inv_target", target_floor, 3'd1);
        car_floor = 3'd0; door_open = 1'b1;
        #1;
        check("inv_pulse", served_pulse, 1'b0);
        tick();
        check("inv_pend", pending, 5'b00001);
        check("inv_busy", busy, 1'b1);
        car_floor = 3'd1;
        #1;
        check("val_pulse", served_pulse, 1'b1);
        tick();
        call_btn = 5'b01000;
        tick();
        call_btn = '0;
        check("hold_pend", pending, 5'b01000);
        check("hold_busy", busy, 1'b1);

        // Async reset mid-HOLD takes effect without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_pend", pending, 5'b00000);
        check("async_target", target_floor, 3'd1);
        check("async_busy", busy, 1'b0);
        check("async_pulse", served_pulse, 1'b0);
        tick();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
